// File: rtl/hazard_controller.sv
// Execute-stage hazard control: M/W destination shadows, operand forwarding selects,
// load-use / redirect stall-flush generation and saturating event counters.
// Build option HAZARD_FORWARD_EN: when undefined, forwarding is off and a full RAW interlock stalls instead.
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic [4:0]       E_rs1,
  input  logic [4:0]       E_rs2,
  input  logic [4:0]       E_rd,
  input  logic             E_reg_write,
  input  logic             E_result_is_load,
  input  logic             E_redirect,
  output logic [1:0]       E_forward_src_a_sel,
  output logic [1:0]       E_forward_src_b_sel,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_flush,
  output logic             E_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [4:0]       m_rd_q;
  logic             m_reg_write_q;
  logic             m_is_load_q;
  logic [4:0]       w_rd_q;
  logic             w_reg_write_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic             hazard_s;
  logic             unused_ok;

`ifdef HAZARD_FORWARD_EN
  // M beats W; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
      return 2'b01;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  assign E_forward_src_a_sel = fwd_sel(E_rs1, m_rd_q, m_reg_write_q, w_rd_q, w_reg_write_q);
  assign E_forward_src_b_sel = fwd_sel(E_rs2, m_rd_q, m_reg_write_q, w_rd_q, w_reg_write_q);
  assign hazard_s = E_result_is_load & E_reg_write & (E_rd != 5'd0)
                  & ((E_rd == D_rs1) | (E_rd == D_rs2));
  assign unused_ok = m_is_load_q;
`else
  function automatic logic producer_hit(input logic [4:0] rd, input logic we,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return we & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
  endfunction

  assign E_forward_src_a_sel = 2'b00;
  assign E_forward_src_b_sel = 2'b00;
  assign hazard_s = producer_hit(E_rd, E_reg_write, D_rs1, D_rs2)
                  | producer_hit(m_rd_q, m_reg_write_q, D_rs1, D_rs2)
                  | producer_hit(w_rd_q, w_reg_write_q, D_rs1, D_rs2);
  assign unused_ok = ^{E_rs1, E_rs2, E_result_is_load, m_is_load_q};
`endif

  // A redirect makes the dependent instruction wrong-path, so it flushes instead of stalling.
  assign F_stall = hazard_s & ~E_redirect;
  assign D_stall = hazard_s & ~E_redirect;
  assign E_flush = hazard_s | E_redirect;
  assign D_flush = E_redirect;

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (F_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (E_redirect && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Shadows never stall; bubbles arrive through E_reg_write=0 from the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rd_q        <= 5'd0;
      m_reg_write_q <= 1'b0;
      m_is_load_q   <= 1'b0;
      w_rd_q        <= 5'd0;
      w_reg_write_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      m_rd_q        <= E_rd;
      m_reg_write_q <= E_reg_write;
      m_is_load_q   <= E_result_is_load;
      w_rd_q        <= m_rd_q;
      w_reg_write_q <= m_reg_write_q;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; expectations follow the HAZARD_FORWARD_EN build option.
module tb_hazard_controller;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk, rst;
  logic [4:0] D_rs1, D_rs2, E_rs1, E_rs2, E_rd;
  logic       E_reg_write, E_result_is_load, E_redirect;
  logic [1:0] sel_a, sel_b;
  logic       F_stall, D_stall, D_flush, E_flush;
  logic [3:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  hazard_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .D_rs1(D_rs1), .D_rs2(D_rs2), .E_rs1(E_rs1), .E_rs2(E_rs2), .E_rd(E_rd),
    .E_reg_write(E_reg_write), .E_result_is_load(E_result_is_load), .E_redirect(E_redirect),
    .E_forward_src_a_sel(sel_a), .E_forward_src_b_sel(sel_b),
    .F_stall(F_stall), .D_stall(D_stall), .D_flush(D_flush), .E_flush(E_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    D_rs1 = 5'd0; D_rs2 = 5'd0; E_rs1 = 5'd0; E_rs2 = 5'd0; E_rd = 5'd0;
    E_reg_write = 1'b0; E_result_is_load = 1'b0; E_redirect = 1'b0;
  endtask

  task automatic chk_ctl(input string tag, input logic fs, input logic ds,
                         input logic df, input logic ef);
    chk({tag, "_fstall"}, 32'(F_stall), 32'(fs));
    chk({tag, "_dstall"}, 32'(D_stall), 32'(ds));
    chk({tag, "_dflush"}, 32'(D_flush), 32'(df));
    chk({tag, "_eflush"}, 32'(E_flush), 32'(ef));
  endtask

  initial begin
    rst = 1'b1;
    clr();
    #1;
    chk("rst_sel_a", 32'(sel_a), 32'd0);
    chk("rst_sel_b", 32'(sel_b), 32'd0);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // EX forward: producer x5, then consumer on both operands
    E_rd = 5'd5; E_reg_write = 1'b1;
    #1 chk_ctl("exf_prod", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    clr(); E_rs1 = 5'd5; E_rs2 = 5'd5;
    #1;
    chk("exf_sel_a", 32'(sel_a), FWD ? 32'd1 : 32'd0);
    chk("exf_sel_b", 32'(sel_b), FWD ? 32'd1 : 32'd0);
    tick();
    // x0 producer never forwards
    clr(); E_rd = 5'd0; E_reg_write = 1'b1;
    tick();
    clr();
    #1;
    chk("x0_sel_a", 32'(sel_a), 32'd0);
    chk("x0_sel_b", 32'(sel_b), 32'd0);

    // Priority: x7 in both M and W, then only W
    tick(); tick();
    E_rd = 5'd7; E_reg_write = 1'b1;
    tick(); tick();
    clr(); E_rs2 = 5'd7;
    #1 chk("pri_mw_sel_b", 32'(sel_b), FWD ? 32'd1 : 32'd0);
    tick();
    #1 chk("pri_w_sel_b", 32'(sel_b), FWD ? 32'd2 : 32'd0);
    tick(); tick(); tick();

    // Load-use: load x3 in E, consumer reads x3 as rs2 in D
    clr(); E_rd = 5'd3; E_reg_write = 1'b1; E_result_is_load = 1'b1; D_rs2 = 5'd3;
    #1 chk_ctl("lu", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);
    clr(); D_rs2 = 5'd3;
    #1 chk_ctl("lu_bubble", !FWD, !FWD, 1'b0, !FWD);
    tick();
    clr(); E_rs2 = 5'd3;
    #1;
    chk("lu_w_sel_b", 32'(sel_b), FWD ? 32'd2 : 32'd0);
    chk("lu_dep_fstall", 32'(F_stall), 32'd0);
    chk("lu_stall_cnt2", 32'(stall_count), FWD ? 32'd1 : 32'd2);
    tick(); tick(); tick();

    // Redirect wins over load-use
    clr(); E_rd = 5'd3; E_reg_write = 1'b1; E_result_is_load = 1'b1; D_rs2 = 5'd3;
    E_redirect = 1'b1;
    #1 chk_ctl("redir", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    clr();
    #1;
    chk("redir_flush_cnt", 32'(flush_count), 32'd1);
    chk("redir_stall_cnt", 32'(stall_count), FWD ? 32'd1 : 32'd2);

    // Asynchronous reset while x5 is tracked in M
    E_rd = 5'd5; E_reg_write = 1'b1;
    tick();
    clr(); E_rs1 = 5'd5;
    #1 chk("prerst_sel_a", 32'(sel_a), FWD ? 32'd1 : 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sel_a", 32'(sel_a), 32'd0);
    chk("midrst_stall_cnt", 32'(stall_count), 32'd0);
    chk("midrst_flush_cnt", 32'(flush_count), 32'd0);
    tick();
    rst = 1'b0;
    #1 chk("postrst_sel_a", 32'(sel_a), 32'd0);

    // Saturation of the 4-bit flush counter
    clr(); E_redirect = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat_flush_14", 32'(flush_count), 32'd14);
      if (k == 15) chk("sat_flush_15", 32'(flush_count), 32'd15);
      if (k == 20) chk("sat_flush_20", 32'(flush_count), 32'd15);
    end
    chk("sat_stall_cnt", 32'(stall_count), 32'd0);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
